// File: rtl/stack_mem_responder.sv
// stack_mem_responder: data-memory responder for the stack CPU. Holds the
// stack RAM plus an I/O page (SEG1/SEG2 display registers, free-running
// cycle counter) so display output is just an ordinary store.
//
// Ports:
//   clock, reset        - single clock domain, asynchronous active-high reset
//   address_ram         - 16-bit word address, decoded every edge
//   wren_ram, data_ram  - write strobe and write data
//   q_ram               - registered read data (READ_LAT edges after address)
//   SEG1, SEG2          - display registers at IO_BASE+0 / IO_BASE+1
//   err                 - sticky flag, set by any access to an unmapped address
//
// Optional build macro: RAM_WR_FWD_EN -- a same-edge write and read of one
// location returns the written data instead of the old contents.

module stack_mem_responder #(
  parameter int          DEPTH    = 256,
  parameter int          READ_LAT = 1,
  parameter logic [15:0] IO_BASE  = 16'hFF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address_ram,
  input  logic        wren_ram,
  input  logic [15:0] data_ram,
  output logic [15:0] q_ram,
  output logic [15:0] SEG1,
  output logic [15:0] SEG2,
  output logic        err
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);
  localparam logic [15:0] SEG1_A  = IO_BASE;
  localparam logic [15:0] SEG2_A  = IO_BASE + 16'd1;
  localparam logic [15:0] CNT_A   = IO_BASE + 16'd2;

  logic [15:0] mem [0:DEPTH-1];
  logic [15:0] cnt;
  logic [15:0] rd_q;     // first read stage, captured at the address edge
  logic [15:0] rd_q2;    // extra output stage used when READ_LAT == 2
  logic [15:0] rd_next;
  logic        unmapped;

  wire [AW-1:0] idx     = address_ram[AW-1:0];
  wire          is_ram  = (address_ram < DEPTH16);
  wire          is_seg1 = (address_ram == SEG1_A);
  wire          is_seg2 = (address_ram == SEG2_A);
  wire          is_cnt  = (address_ram == CNT_A);

  // Read mux. Feeds a register only, so q_ram never sees address_ram
  // combinationally.
  always_comb begin
    rd_next  = 16'h0000;
    unmapped = 1'b0;
    if (is_ram)       rd_next = mem[idx];
    else if (is_seg1) rd_next = SEG1;
    else if (is_seg2) rd_next = SEG2;
    else if (is_cnt)  rd_next = cnt;   // value before this edge's increment
    else              unmapped = 1'b1;
`ifdef RAM_WR_FWD_EN
    if (wren_ram) begin
      if (is_ram || is_seg1 || is_seg2) rd_next = data_ram;
      else if (is_cnt)                  rd_next = 16'h0000;
    end
`endif
  end

  // RAM contents survive reset; writes are still blocked while reset is high.
  always_ff @(posedge clock) begin
    if (!reset && wren_ram && is_ram) mem[idx] <= data_ram;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= 16'h0000;
      SEG1  <= 16'h0000;
      SEG2  <= 16'h0000;
      err   <= 1'b0;
      rd_q  <= 16'h0000;
      rd_q2 <= 16'h0000;
    end else begin
      // A clear via store takes priority over the free-running increment.
      cnt <= (wren_ram && is_cnt) ? 16'h0000 : cnt + 16'd1;
      if (wren_ram && is_seg1) SEG1 <= data_ram;
      if (wren_ram && is_seg2) SEG2 <= data_ram;
      // Reads happen every edge, so this also covers unmapped writes.
      if (unmapped) err <= 1'b1;
      rd_q  <= rd_next;
      rd_q2 <= rd_q;
    end
  end

  assign q_ram = (READ_LAT == 2) ? rd_q2 : rd_q;

endmodule

// File: tb/tb_stack_mem_responder.sv
module tb_stack_mem_responder;
  parameter int RL = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address_ram = 16'h0000;
  logic        wren_ram = 1'b0;
  logic [15:0] data_ram = 16'h0000;
  logic [15:0] q_ram, SEG1, SEG2;
  logic        err;

  stack_mem_responder #(.DEPTH(256), .READ_LAT(RL), .IO_BASE(16'hFF00)) dut (
    .clock(clock), .reset(reset), .address_ram(address_ram), .wren_ram(wren_ram),
    .data_ram(data_ram), .q_ram(q_ram), .SEG1(SEG1), .SEG2(SEG2), .err(err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          due;
    logic [15:0] exp;
    string       nm;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: q_ram is compared on the falling edge of the cycle it is due.
  always @(negedge clock) begin
    if (!reset) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        tests = tests + 1;
        fails = fails + 1;
        $display("FAIL %s: response never checked, due cycle %0d now %0d", sb[0].nm, sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        chk(sb[0].nm, q_ram, sb[0].exp);
        void'(sb.pop_front());
      end
    end
  end

  // One edge of stimulus; optionally queue the read result expected from it.
  task automatic step(input logic [15:0] a, input logic w, input logic [15:0] d,
                      input logic c, input logic [15:0] e, input string nm);
    exp_t x;
    address_ram = a;
    wren_ram    = w;
    data_ram    = d;
    @(posedge clock);
    #1;
    if (c) begin
      x.due = cyc + RL - 1;
      x.exp = e;
      x.nm  = nm;
      sb.push_back(x);
    end
    wren_ram = 1'b0;
  endtask

  task automatic drain();
    repeat (RL + 2) @(posedge clock);
    #1;
  endtask

  localparam logic [15:0] A_SEG1 = 16'hFF00;
  localparam logic [15:0] A_SEG2 = 16'hFF01;
  localparam logic [15:0] A_CNT  = 16'hFF02;

  initial begin
    // Reset values
    repeat (2) @(posedge clock);
    #1;
    chk("rst_q_ram", q_ram, 16'h0000);
    chk("rst_seg1", SEG1, 16'h0000);
    chk("rst_seg2", SEG2, 16'h0000);
    chk("rst_err", {15'd0, err}, 16'h0000);
    reset = 1'b0;

    // RAM write then read
    step(16'h0003, 1, 16'hBEEF, 0, 16'h0, "");
    step(16'h0003, 0, 16'h0000, 1, 16'hBEEF, "ram_rd_3");

    // Stack-machine push/pop pattern
    step(16'h0000, 1, 16'h0005, 0, 16'h0, "");
    step(16'h0001, 1, 16'h0007, 0, 16'h0, "");
    step(16'h0001, 0, 16'h0000, 1, 16'h0007, "stack_rd_1");
    step(16'h0000, 0, 16'h0000, 1, 16'h0005, "stack_rd_0");

    // Read-during-write collisions
    step(16'h0004, 1, 16'h0011, 0, 16'h0, "");
`ifdef RAM_WR_FWD_EN
    step(16'h0004, 1, 16'h0022, 1, 16'h0022, "coll_ram_same_edge");
`else
    step(16'h0004, 1, 16'h0022, 1, 16'h0011, "coll_ram_same_edge");
`endif
    step(16'h0004, 0, 16'h0000, 1, 16'h0022, "coll_ram_next");
    step(A_SEG1, 1, 16'h1111, 0, 16'h0, "");
`ifdef RAM_WR_FWD_EN
    step(A_SEG1, 1, 16'h2222, 1, 16'h2222, "coll_seg1_same_edge");
`else
    step(A_SEG1, 1, 16'h2222, 1, 16'h1111, "coll_seg1_same_edge");
`endif
    chk("coll_seg1_reg", SEG1, 16'h2222);

    // I/O page
    step(A_SEG1, 1, 16'h5A5A, 0, 16'h0, "");
    step(A_SEG2, 1, 16'h00A5, 0, 16'h0, "");
    chk("seg2_write", SEG2, 16'h00A5);
    chk("seg1_unchanged", SEG1, 16'h5A5A);
    step(A_SEG1, 0, 16'h0000, 1, 16'h5A5A, "seg1_rd");
    step(A_SEG2, 0, 16'h0000, 1, 16'h00A5, "seg2_rd");

    // Top RAM word is mapped
    step(16'h00FF, 1, 16'hCAFE, 0, 16'h0, "");
    step(16'h00FF, 0, 16'h0000, 1, 16'hCAFE, "ram_rd_top");
    drain();
    chk("err_clear_mapped", {15'd0, err}, 16'h0000);

    // Counter: clear at edge E0; read at E0+k returns k-1
    step(A_CNT, 1, 16'hFFFF, 0, 16'h0, "");
    step(A_CNT, 0, 16'h0000, 1, 16'h0000, "cnt_rd_k1");
    step(A_CNT, 0, 16'h0000, 1, 16'h0001, "cnt_rd_k2");
    step(A_CNT, 0, 16'h0000, 1, 16'h0002, "cnt_rd_k3");
    step(A_CNT, 0, 16'h0000, 1, 16'h0003, "cnt_rd_k4");

    // Unmapped accesses
    step(16'h8000, 0, 16'h0000, 1, 16'h0000, "unmapped_rd");
    drain();
    chk("err_set", {15'd0, err}, 16'h0001);
    step(16'h8001, 1, 16'hDEAD, 0, 16'h0, "");
    chk("unmapped_wr_seg1", SEG1, 16'h5A5A);
    chk("unmapped_wr_seg2", SEG2, 16'h00A5);
    step(16'h0001, 0, 16'h0000, 1, 16'h0007, "unmapped_wr_ram1");
    step(16'h0003, 0, 16'h0000, 1, 16'hBEEF, "unmapped_wr_ram3");
    step(16'h0100, 0, 16'h0000, 1, 16'h0000, "rd_depth_boundary");
    step(16'hFF03, 0, 16'h0000, 1, 16'h0000, "rd_io_plus3");
    drain();
    chk("err_sticky", {15'd0, err}, 16'h0001);

    // Counter wrap: clear, idle 65535 edges, then read 0xFFFF then 0x0000
    step(A_CNT, 1, 16'h0000, 0, 16'h0, "");
    for (int k = 1; k <= 65535; k++) step(A_CNT, 0, 16'h0000, 0, 16'h0, "");
    step(A_CNT, 0, 16'h0000, 1, 16'hFFFF, "cnt_max");
    step(A_CNT, 0, 16'h0000, 1, 16'h0000, "cnt_wrap");

    // Reset mid-run
    step(A_SEG1, 1, 16'h1234, 0, 16'h0, "");
    chk("seg1_pre_reset", SEG1, 16'h1234);
    step(A_SEG1, 0, 16'h0000, 1, 16'h1234, "seg1_rd_pre_reset");
    address_ram = A_SEG1;
    drain();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_q_ram", q_ram, 16'h0000);
    chk("mid_rst_seg1", SEG1, 16'h0000);
    chk("mid_rst_err", {15'd0, err}, 16'h0000);
    address_ram = A_SEG2;
    wren_ram    = 1'b1;
    data_ram    = 16'h7777;
    @(posedge clock);
    #1;
    address_ram = 16'h0003;
    data_ram    = 16'h9999;
    @(posedge clock);
    #1;
    wren_ram = 1'b0;
    chk("rst_hold_q_ram", q_ram, 16'h0000);
    reset = 1'b0;
    chk("rst_wr_seg2_blocked", SEG2, 16'h0000);
    step(16'h0003, 0, 16'h0000, 1, 16'hBEEF, "rst_wr_ram_blocked");
    drain();

    tests = tests + 1;
    if (sb.size() != 0) begin
      fails = fails + 1;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
